// File: rtl/iir_pkg.sv
// Shared types and helpers for the time-multiplexed IIR filter.
package iir_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFf,
        StFb,
        StOut
    } state_e;

    localparam logic CoefSelFf = 1'b0;
    localparam logic CoefSelFb = 1'b1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) res = i + 1;
        end
        return res;
    endfunction

    // Clamp an unsigned value to the largest number representable in width bits.
    function automatic logic [63:0] sat_trunc(input logic [63:0] value, input int unsigned width);
        logic [63:0] max_val;
        max_val = (64'd1 << width) - 64'd1;
        return (value > max_val) ? max_val : value;
    endfunction

endpackage

// File: rtl/iir_seq_filter_if.sv
// Sample, result and coefficient-write signals of the sequential IIR filter.
interface iir_seq_filter_if
    import iir_pkg::*;
#(
    parameter int unsigned ORDER  = 8,
    parameter int unsigned DIN_W  = 8,
    parameter int unsigned COEF_W = 8,
    parameter int unsigned DOUT_W = 17
);
    localparam int unsigned AddrW = clog2(ORDER + 1);

    logic              in_valid;
    logic              in_ready;
    logic [DIN_W-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DOUT_W-1:0] out_data;
    logic              coef_we;
    logic              coef_sel;
    logic [AddrW-1:0]  coef_addr;
    logic [COEF_W-1:0] coef_wdata;
    logic              clear_hist;

    modport master (
        output in_valid, in_data, out_ready, coef_we, coef_sel, coef_addr, coef_wdata,
               clear_hist,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready, coef_we, coef_sel, coef_addr, coef_wdata,
               clear_hist,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/iir_mac_unit.sv
// Single multiply-accumulate stage shared by all filter taps.
module iir_mac_unit
    import iir_pkg::*;
#(
    parameter int unsigned DIN_W  = 8,
    parameter int unsigned COEF_W = 8,
    parameter int unsigned DOUT_W = 17,
    parameter int unsigned ACC_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              en_i,
    input  logic [DIN_W-1:0]  sample_i,
    input  logic [COEF_W-1:0] coef_i,
    output logic [DOUT_W-1:0] sat_o
);
    localparam int unsigned ProdW = DIN_W + COEF_W;

    logic [ProdW-1:0] prod;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W-1:0] acc_q, acc_d;

    always_comb begin
        prod     = ProdW'(sample_i) * ProdW'(coef_i);
        acc_next = acc_q + ACC_W'(prod);
        sat_o    = DOUT_W'(sat_trunc(64'(acc_next), DOUT_W));
        acc_d    = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

endmodule

// File: rtl/iir_seq_filter.sv
// Time-multiplexed unsigned IIR filter: one MAC walks the feedforward then feedback taps.
module iir_seq_filter
    import iir_pkg::*;
#(
    parameter int unsigned ORDER    = 8,
    parameter int unsigned DIN_W    = 8,
    parameter int unsigned COEF_W   = 8,
    parameter int unsigned DOUT_W   = 17,
    parameter int unsigned ACC_W    = 24,
    parameter int unsigned FB_SHIFT = 9
) (
    input logic           clk,
    input logic           rst,
    iir_seq_filter_if.slave bus
);
    localparam int unsigned      AddrW   = clog2(ORDER + 1);
    localparam logic [AddrW-1:0] LastTap = AddrW'(ORDER);

    state_e            state_q, state_d;
    logic [AddrW-1:0]  k_q, k_d;
    logic [DIN_W-1:0]  x_q [ORDER+1];
    logic [DIN_W-1:0]  x_d [ORDER+1];
    // Index 0 of the feedback history and of a[] is never used.
    logic [DIN_W-1:0]  y_q [ORDER+1];
    logic [DIN_W-1:0]  y_d [ORDER+1];
    logic [COEF_W-1:0] b_q [ORDER+1];
    logic [COEF_W-1:0] b_d [ORDER+1];
    logic [COEF_W-1:0] a_q [ORDER+1];
    logic [COEF_W-1:0] a_d [ORDER+1];
    logic [DOUT_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;

    logic              in_ready;
    logic              mac_clear;
    logic              mac_en;
    logic [DIN_W-1:0]  mac_sample;
    logic [COEF_W-1:0] mac_coef;
    logic [DOUT_W-1:0] mac_sat;
    logic [DIN_W-1:0]  fb_val;

    iir_mac_unit #(
        .DIN_W (DIN_W),
        .COEF_W(COEF_W),
        .DOUT_W(DOUT_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .clear_i (mac_clear),
        .en_i    (mac_en),
        .sample_i(mac_sample),
        .coef_i  (mac_coef),
        .sat_o   (mac_sat)
    );

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        x_d         = x_q;
        y_d         = y_q;
        b_d         = b_q;
        a_d         = a_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        in_ready    = 1'b0;
        mac_clear   = 1'b0;
        mac_en      = 1'b0;
        mac_sample  = '0;
        mac_coef    = '0;
        fb_val      = DIN_W'(sat_trunc(64'(mac_sat >> FB_SHIFT), DIN_W));

        unique case (state_q)
            StIdle: begin
                in_ready = ~bus.clear_hist;
                if (bus.coef_we && (bus.coef_addr <= LastTap)) begin
                    if (bus.coef_sel == CoefSelFf) begin
                        b_d[bus.coef_addr] = bus.coef_wdata;
                    end else if (bus.coef_addr != '0) begin
                        a_d[bus.coef_addr] = bus.coef_wdata;
                    end
                end
                if (bus.clear_hist) begin
                    x_d = '{default: '0};
                    y_d = '{default: '0};
                end else if (bus.in_valid) begin
                    for (int unsigned i = 1; i <= ORDER; i++) x_d[i] = x_q[i-1];
                    x_d[0]    = bus.in_data;
                    mac_clear = 1'b1;
                    k_d       = '0;
                    state_d   = StFf;
                end
            end
            StFf: begin
                mac_en     = 1'b1;
                mac_sample = x_q[k_q];
                mac_coef   = b_q[k_q];
                if (k_q == LastTap) begin
                    k_d     = AddrW'(1);
                    state_d = StFb;
                end else begin
                    k_d = k_q + AddrW'(1);
                end
            end
            StFb: begin
                mac_en     = 1'b1;
                mac_sample = y_q[k_q];
                mac_coef   = a_q[k_q];
                if (k_q == LastTap) begin
                    out_data_d  = mac_sat;
                    out_valid_d = 1'b1;
                    for (int unsigned i = 2; i <= ORDER; i++) y_d[i] = y_q[i-1];
                    y_d[1]  = fb_val;
                    state_d = StOut;
                end else begin
                    k_d = k_q + AddrW'(1);
                end
            end
            StOut: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            k_q         <= '0;
            x_q         <= '{default: '0};
            y_q         <= '{default: '0};
            b_q         <= '{default: '0};
            b_q[0]      <= COEF_W'(1);
            a_q         <= '{default: '0};
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            x_q         <= x_d;
            y_q         <= y_d;
            b_q         <= b_d;
            a_q         <= a_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_iir_seq_filter.sv
// Scoreboard bench for iir_seq_filter: directed samples, queued expectations, separate monitor.
module tb_iir_seq_filter;
    import iir_pkg::*;

    localparam int unsigned ORDER    = 8;
    localparam int unsigned DIN_W    = 8;
    localparam int unsigned COEF_W   = 8;
    localparam int unsigned DOUT_W   = 17;
    localparam int unsigned ACC_W    = 24;
    localparam int unsigned FB_SHIFT = 9;
    localparam int unsigned AW       = clog2(ORDER + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    iir_seq_filter_if #(
        .ORDER (ORDER),
        .DIN_W (DIN_W),
        .COEF_W(COEF_W),
        .DOUT_W(DOUT_W)
    ) bus ();

    iir_seq_filter #(
        .ORDER   (ORDER),
        .DIN_W   (DIN_W),
        .COEF_W  (COEF_W),
        .DOUT_W  (DOUT_W),
        .ACC_W   (ACC_W),
        .FB_SHIFT(FB_SHIFT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_q[$];
    int cyc     = 0;
    int acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    logic              prev_valid = 1'b0;
    logic              prev_ready = 1'b0;
    logic [DOUT_W-1:0] prev_data  = '0;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_valid = 1'b0;
                continue;
            end
            if (bus.out_valid) begin
                if (!prev_valid) check("latency", cyc - acc_cyc, 17);
                else if (!prev_ready) check("stall_hold", bus.out_data, prev_data);
                check("in_ready_busy", bus.in_ready, 0);
                if (bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_output: got %0d, none expected", bus.out_data);
                    end else begin
                        check("out_data", bus.out_data, exp_q.pop_front());
                    end
                end
            end
            prev_valid = bus.out_valid;
            prev_ready = bus.out_ready;
            prev_data  = bus.out_data;
        end
    end

    task automatic send(input int d, input bit expect_out, input int exp);
        int waited;
        waited = 0;
        if (expect_out) exp_q.push_back(exp);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = DIN_W'(d);
        #1;
        while (!bus.in_ready) begin
            if (waited > 200) begin
                n_cmp++;
                n_fail++;
                $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
                bus.in_valid = 1'b0;
                return;
            end
            waited++;
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        acc_cyc      = cyc;
        bus.in_valid = 1'b0;
    endtask

    task automatic wr(input logic sel, input int addr, input int val);
        @(negedge clk);
        bus.coef_we    = 1'b1;
        bus.coef_sel   = sel;
        bus.coef_addr  = AW'(addr);
        bus.coef_wdata = COEF_W'(val);
        @(negedge clk);
        bus.coef_we = 1'b0;
    endtask

    task automatic clear();
        @(negedge clk);
        bus.clear_hist = 1'b1;
        @(negedge clk);
        bus.clear_hist = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (bus.in_ready && !bus.out_valid && exp_q.size() == 0) return;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL idle_timeout: %0d results outstanding, expected 0", exp_q.size());
    endtask

    int b_tri[9] = '{1, 2, 4, 8, 16, 8, 4, 2, 1};

    initial begin
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b1;
        bus.coef_we    = 1'b0;
        bus.coef_sel   = CoefSelFf;
        bus.coef_addr  = '0;
        bus.coef_wdata = '0;
        bus.clear_hist = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_in_ready", bus.in_ready, 1);

        // Pass-through after reset.
        send(200, 1, 200);
        send(0, 1, 0);
        send(0, 1, 0);

        // Triangular FIR impulse response.
        wait_idle();
        for (int k = 0; k <= 8; k++) wr(CoefSelFf, k, b_tri[k]);
        clear();
        for (int k = 0; k <= 8; k++) send((k == 0) ? 10 : 0, 1, b_tri[k] * 10);
        send(0, 1, 0);

        // Feedback path: 65025 >> 9 = 127, times a[1] = 2.
        wait_idle();
        wr(CoefSelFf, 0, 255);
        for (int k = 1; k <= 8; k++) wr(CoefSelFf, k, 0);
        wr(CoefSelFb, 1, 2);
        clear();
        send(255, 1, 65025);
        send(0, 1, 254);

        // Saturation, then read y[1] back through a[1] = 1.
        wait_idle();
        wr(CoefSelFb, 1, 0);
        for (int k = 0; k <= 8; k++) wr(CoefSelFf, k, 255);
        clear();
        for (int i = 1; i <= 9; i++) send(255, 1, (65025 * i > 131071) ? 131071 : 65025 * i);
        wait_idle();
        for (int k = 0; k <= 8; k++) wr(CoefSelFf, k, 0);
        wr(CoefSelFb, 1, 1);
        send(0, 1, 255);

        // Backpressure with ignored input and coefficient write.
        wait_idle();
        wr(CoefSelFb, 1, 0);
        wr(CoefSelFf, 0, 1);
        clear();
        @(negedge clk);
        bus.out_ready = 1'b0;
        send(77, 1, 77);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (bus.out_valid) break;
        end
        check("bp_valid", bus.out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid   = 1'b1;
            bus.in_data    = DIN_W'(99);
            bus.coef_we    = 1'b1;
            bus.coef_sel   = CoefSelFf;
            bus.coef_addr  = '0;
            bus.coef_wdata = COEF_W'(3);
            #1;
            check("bp_in_ready", bus.in_ready, 0);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.coef_we   = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp_release", bus.out_valid, 0);
        wait_idle();
        wr(CoefSelFb, 0, 200);
        wr(CoefSelFf, 9, 200);
        send(5, 1, 5);

        // Reset during FB aborts the result; clear blocks accept.
        wait_idle();
        send(50, 0, 0);
        repeat (12) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_in_ready", bus.in_ready, 1);
        @(negedge clk);
        bus.clear_hist = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_data    = DIN_W'(9);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("clear_in_ready", bus.in_ready, 0);
            @(negedge clk);
        end
        bus.clear_hist = 1'b0;
        bus.in_valid   = 1'b0;
        for (int k = 0; k <= 8; k++) wr(CoefSelFf, k, 1);
        for (int k = 1; k <= 8; k++) wr(CoefSelFb, k, 1);
        send(9, 1, 9);

        wait_idle();
        repeat (20) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1);
    end

endmodule
